// File: rtl/io_dma_pkg.sv
// io_dma_pkg: shared types and constants for the IO-port DMA engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_dma_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_DUMP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WLAST = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/io_dma_outbuf.sv
// io_dma_outbuf: single-entry valid/ready output register for the DUMP stream.
// Latency: one cycle from load_i to valid_o.
// Backpressure: data_o/valid_o hold while valid_o & !ready_i; space_o tells the producer it may load.
module io_dma_outbuf #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              space_o
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    // Load a new word, or retire the held one once the consumer takes it.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            dat_d = data_i;
            vld_d = 1'b1;
        end else if (ready_i) begin
            vld_d = 1'b0;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign data_o  = dat_q;
    assign valid_o = vld_q;
    assign space_o = !vld_q || ready_i;

endmodule

// File: rtl/io_dma_engine.sv
// io_dma_engine: moves a block of words between a stream port and the IO side of program/data memory.
// Latency: LOAD strobe 1 cycle after each handshake, DONE 1 cycle after last strobe; DUMP first M_VALID 2 cycles after START.
// Backpressure: S_READY held high through LOAD; DUMP stops reading while M_VALID & !M_READY.
// Optional feature macro: IO_DMA_CHECKSUM_EN adds the CHECKSUM port and its running 16-bit word sum.
module io_dma_engine
    import io_dma_pkg::*;
#(
    parameter int MEM_SIZE = 200,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              DIR,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [15:0]       LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [DATA_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [ADDR_W-1:0] RADDR_IO,
    input  logic [DATA_W-1:0] DATA_OUT_IO,
    output logic [ADDR_W-1:0] WADDR_IO,
    output logic [DATA_W-1:0] DATA_IN_IO,
    output logic              MW_IO_ON
`ifdef IO_DMA_CHECKSUM_EN
    ,
    output logic [15:0]       CHECKSUM
`endif
);

    // One bit wider than the wider of address and length so base+len cannot wrap.
    localparam int SUM_W = ((ADDR_W > 16) ? ADDR_W : 16) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mw_q, mw_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              capture;
    logic              buf_space;
    logic              range_bad;
`ifdef IO_DMA_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    assign range_bad = (SUM_W'(BASE_ADDR) + SUM_W'(LEN)) > SUM_W'(MEM_SIZE);

    // Next-state and datapath decisions; everything defaults to hold or idle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rd_en_d = rd_en_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        mw_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
`ifdef IO_DMA_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
`ifdef IO_DMA_CHECKSUM_EN
                        csum_d = '0;
`endif
                        if (LEN == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            addr_d = BASE_ADDR;
                            rem_d  = LEN;
                            if (DIR == DIR_DUMP) begin
                                state_d = ST_DUMP;
                                rd_en_d = 1'b1;
                            end else begin
                                state_d = ST_LOAD;
                            end
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (S_VALID) begin
                    waddr_d = addr_q;
                    wdata_d = S_DATA;
                    mw_d    = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - 16'd1;
`ifdef IO_DMA_CHECKSUM_EN
                    csum_d  = csum_q + 16'(S_DATA);
`endif
                    if (rem_q == 16'd1) begin
                        state_d = ST_WLAST;
                    end
                end
            end
            ST_WLAST: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_DUMP: begin
                if (buf_space) begin
                    capture = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - 16'd1;
`ifdef IO_DMA_CHECKSUM_EN
                    csum_d  = csum_q + 16'(DATA_OUT_IO);
`endif
                    if (rem_q == 16'd1) begin
                        rd_en_d = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (M_VALID && M_READY) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer and drops a pending strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rd_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            mw_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IO_DMA_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rd_en_q <= rd_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mw_q    <= mw_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IO_DMA_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    io_dma_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (capture),
        .data_i  (DATA_OUT_IO),
        .ready_i (M_READY),
        .data_o  (M_DATA),
        .valid_o (M_VALID),
        .space_o (buf_space)
    );

    // All-z on the read address is the memory's "no read" request.
    assign RADDR_IO   = rd_en_q ? addr_q : {ADDR_W{1'bz}};
    assign WADDR_IO   = waddr_q;
    assign DATA_IN_IO = wdata_q;
    assign MW_IO_ON   = mw_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign S_READY    = (state_q == ST_LOAD);
    assign DONE       = done_q;
    assign ERR        = err_q;
`ifdef IO_DMA_CHECKSUM_EN
    assign CHECKSUM   = csum_q;
`endif

endmodule

// File: doc/io_dma_engine.md
# io_dma_engine

Initiator for the IO port of the shared dual-port program/data memory. Moves a contiguous block of 16-bit words between an external stream and memory: LOAD streams words in and writes them through the IO write port; DUMP reads through the IO read port and streams words out. The block sits between the board-level IO/loader logic and the memory's IO side. The CPU side of the memory is untouched.

## Interface
Parameters:
- MEM_SIZE, 200, number of memory words; the legal address range is 0..MEM_SIZE-1.
- ADDR_W, 16, address width.
- DATA_W, 16, word width.

Ports:
- CLK  in  1  clock; all registers update on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  command strobe; sampled only in IDLE.
- DIR  in  1  0 = LOAD (stream to memory), 1 = DUMP (memory to stream); sampled with START.
- BASE_ADDR  in  ADDR_W  first word address; sampled with START.
- LEN  in  16  word count; sampled with START.
- BUSY  out  1  high while a transfer is in progress.
- DONE  out  1  one-cycle pulse at transfer completion.
- ERR  out  1  one-cycle pulse when a command is rejected.
- S_DATA  in  DATA_W  LOAD input word.
- S_VALID  in  1  LOAD input valid.
- S_READY  out  1  LOAD input ready.
- M_DATA  out  DATA_W  DUMP output word.
- M_VALID  out  1  DUMP output valid.
- M_READY  in  1  DUMP output ready.
- RADDR_IO  out  ADDR_W  memory IO read address.
- DATA_OUT_IO  in  DATA_W  memory IO read data; combinational from RADDR_IO.
- WADDR_IO  out  ADDR_W  memory IO write address.
- DATA_IN_IO  out  DATA_W  memory IO write data.
- MW_IO_ON  out  1  memory IO write strobe; memory commits on the falling edge of CLK.
- CHECKSUM  out  16  running word sum; present only with IO_DMA_CHECKSUM_EN.

## Operation
- States: IDLE, LOAD, WLAST, DUMP, DRAIN.
- **Reset values:** state IDLE. BUSY, DONE, ERR, S_READY, M_VALID, MW_IO_ON = 0. WADDR_IO, DATA_IN_IO, M_DATA = 0. RADDR_IO = 16'hzzzz, which is the memory's "no read" encoding. CHECKSUM = 0.
- **IDLE, START = 1:**
  - If BASE_ADDR + LEN > MEM_SIZE (computed 17-bit): ERR pulses next cycle, state stays IDLE, no memory access.
  - Else if LEN = 0: DONE pulses next cycle, no access.
  - Else: latch address and remaining count, set BUSY, go to LOAD or DUMP.
- **START while BUSY:** ignored.
- **LOAD:**
  - S_READY = 1.
  - Each S_VALID & S_READY handshake registers WADDR_IO = addr, DATA_IN_IO = S_DATA and MW_IO_ON = 1 for exactly the following cycle; then addr+1, remaining-1.
  - Accepting the final word moves the state to WLAST, with S_READY = 0.
- **WLAST:** final write strobe cycle. Next cycle: IDLE, DONE = 1, BUSY = 0.
- **DUMP:**
  - RADDR_IO = addr, registered.
  - When the output register is empty or being consumed (!M_VALID | M_READY), capture DATA_OUT_IO into M_DATA, set M_VALID, then addr+1, remaining-1.
  - After the last capture, RADDR_IO goes to z and the state moves to DRAIN.
- **DRAIN:** when the last word handshakes, go to IDLE with DONE = 1 and BUSY = 0 in the next cycle.
- **Reset mid-transfer:** abort. All outputs return to reset values at the next edge. Writes already committed remain in memory. A pending strobe is dropped.
- **Address arithmetic:** ADDR_W bits. Wrap cannot occur because of the range check.
- **Contention:** the memory applies the IO write before the CPU write on the same falling edge, so the CPU wins on an address collision. The engine does not arbitrate; software avoids overlap.

## Timing
- LOAD throughput: 1 word/cycle. A handshake at edge n gives MW_IO_ON high in cycle n+1, memory updated at the falling edge of n+1. DONE comes one cycle after the last strobe.
- DUMP throughput: 1 word/cycle with M_READY held high. First M_VALID appears 2 cycles after START.
- M_DATA and M_VALID are stable while M_VALID & !M_READY.
- DONE, ERR: exactly one cycle each, registered.

## Configuration
- IO_DMA_CHECKSUM_EN defined:
  - The CHECKSUM port and a 16-bit modulo adder exist.
  - Cleared on accepted START.
  - Adds each word written (LOAD) or captured (DUMP).
  - Holds its value after DONE.
- Undefined: the port and adder are absent, and all other behaviour is identical.

## Structure
- Package io_dma_pkg: state enum, DIR_LOAD/DIR_DUMP constants, ADDR_W/DATA_W defaults.
- Sub-module io_dma_outbuf: single-entry valid/ready output register used by DUMP.

## Test plan
- Reset, then idle for 10 cycles -> all outputs at reset values, MW_IO_ON never high, RADDR_IO = z.
- LOAD with BASE = 16, LEN = 4, words 16'h1111..16'h4444 back-to-back -> memory[16..19] updated, DONE pulse 1 cycle after the last MW_IO_ON, CHECKSUM = 16'hAAAA (when enabled).
- DUMP with BASE = 0, LEN = 9, M_READY toggled 1/0 -> words memory[0..8] in order with none lost or duplicated, M_DATA held while stalled, DONE after the 9th handshake.
- START with BASE = 198, LEN = 3 (MEM_SIZE = 200) -> ERR pulse, no strobe, BUSY stays 0. START with LEN = 0 -> DONE pulse only.
- RST asserted after the 2nd of 5 LOAD words -> exactly 2 words written, outputs reset the next cycle, a new START is accepted afterwards.
- START pulsed during an active DUMP -> ignored; the transfer completes unchanged.
